// File: rtl/prbs_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// prbs_seq_ctrl_if
//   Bundle between the ADC data-generation config registers (master) and the
//   PRBS sequencer (slave). Signal names match the sequencer's port list.
//
//   Config side (master -> slave):
//     start, abort       : sequence request / stop
//     ptrn_mask[3:0]     : bit k enables pattern k (PRBS7/10/15/31)
//     burst_len[CNT_W]   : PRBS cycles per pattern, 0 = 2^CNT_W
//     pre_len[PRE_W]     : toggle preamble cycles per pattern, 0 = none
//     inv_cfg, loop      : inversion, loop-forever
//   Generator / status side (slave -> master):
//     gen_rstb, gen_prbs_en, gen_inv, gen_ptrn_sel[1:0]
//     busy, done, data_vld, seg_cnt[7:0]
// ---------------------------------------------------------------------------
interface prbs_seq_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
);
  logic             start;
  logic             abort;
  logic [3:0]       ptrn_mask;
  logic [CNT_W-1:0] burst_len;
  logic [PRE_W-1:0] pre_len;
  logic             inv_cfg;
  logic             loop;

  logic             gen_rstb;
  logic             gen_prbs_en;
  logic             gen_inv;
  logic [1:0]       gen_ptrn_sel;
  logic             busy;
  logic             done;
  logic             data_vld;
  logic [7:0]       seg_cnt;

  modport master (
    output start, abort, ptrn_mask, burst_len, pre_len, inv_cfg, loop,
    input  gen_rstb, gen_prbs_en, gen_inv, gen_ptrn_sel,
    input  busy, done, data_vld, seg_cnt
  );

  modport slave (
    input  start, abort, ptrn_mask, burst_len, pre_len, inv_cfg, loop,
    output gen_rstb, gen_prbs_en, gen_inv, gen_ptrn_sel,
    output busy, done, data_vld, seg_cnt
  );
endinterface

// File: rtl/prbs_seq_ctrl.sv
// ---------------------------------------------------------------------------
// prbs_seq_ctrl
//   Sequencer for the 1-bit PRBS pattern generator. For every enabled pattern
//   (ascending order) it runs: 1 reset cycle, pre_len toggle cycles, then
//   burst_len PRBS cycles, optionally looping until abort. data_vld marks the
//   PRBS cycles.
//
//   Ports:
//     clk    : clock
//     arstb  : asynchronous active-low reset
//     bus    : prbs_seq_ctrl_if.slave (config in, generator controls/status out)
//
//   Optional feature macro: PRBS_SEQ_STAT_EN
//     defined     -> seg_cnt counts completed PRBS segments since last start
//     not defined -> seg_cnt tied to 0, no counter built
//
//   All outputs are registered; output next-values are decoded from the
//   next state so each state's outputs are visible in the cycle it occupies.
// ---------------------------------------------------------------------------
module prbs_seq_ctrl #(
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
) (
  input logic            clk,
  input logic            arstb,
  prbs_seq_ctrl_if.slave bus
);

  // One shared down-counter serves both PRE and RUN. The extra bit lets a
  // burst_len of 0 be loaded as 2^CNT_W.
  localparam int CW = ((CNT_W > PRE_W) ? CNT_W : PRE_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_PRE  = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Index of the lowest set bit; caller guarantees m != 0.
  function automatic logic [1:0] lowest(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) r = 2'(i);
    return r;
  endfunction

  // {found, idx} of the lowest set bit strictly above cur.
  function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] cur);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--)
      if (m[i] && (i > int'(cur))) r = {1'b1, 2'(i)};
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       mask_q, mask_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             inv_q, inv_d;
  logic             loop_q, loop_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             empty_start;

  logic             gen_rstb_q, gen_rstb_d;
  logic             prbs_en_q, prbs_en_d;
  logic             gen_inv_q, gen_inv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             vld_q, vld_d;

  logic [1:0]       lo_in, lo_q;
  logic [2:0]       nx_q;
  logic [CW-1:0]    blen_ld;

  assign lo_in   = lowest(bus.ptrn_mask);
  assign lo_q    = lowest(mask_q);
  assign nx_q    = next_above(mask_q, ptr_q);
  assign blen_ld = (burst_q == '0) ? (CW'(1) << CNT_W) : CW'(burst_q);

  // -------------------------------------------------------------------------
  // State register (plus latched configuration and pattern pointer)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      burst_q <= '0;
      pre_q   <= '0;
      inv_q   <= 1'b0;
      loop_q  <= 1'b0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      burst_q <= burst_d;
      pre_q   <= pre_d;
      inv_q   <= inv_d;
      loop_q  <= loop_d;
      ptr_q   <= ptr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    burst_d     = burst_q;
    pre_d       = pre_q;
    inv_d       = inv_q;
    loop_d      = loop_q;
    ptr_d       = ptr_q;
    empty_start = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // abort in the same cycle wins over start
        if (bus.start && !bus.abort) begin
          if (bus.ptrn_mask == 4'h0) begin
            empty_start = 1'b1;
          end else begin
            mask_d  = bus.ptrn_mask;
            burst_d = bus.burst_len;
            pre_d   = bus.pre_len;
            inv_d   = bus.inv_cfg;
            loop_d  = bus.loop;
            ptr_d   = lo_in;
            state_d = S_RST;
          end
        end
      end
      S_RST: begin
        if (pre_q == '0) begin
          state_d = S_RUN;
          cnt_d   = blen_ld;
        end else begin
          state_d = S_PRE;
          cnt_d   = CW'(pre_q);
        end
      end
      S_PRE: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_RUN;
          cnt_d   = blen_ld;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RUN: begin
        if (cnt_q == CW'(1)) begin
          if (nx_q[2]) begin
            ptr_d   = nx_q[1:0];
            state_d = S_RST;
          end else if (loop_q) begin
            ptr_d   = lo_q;
            state_d = S_RST;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // abort: straight to IDLE, pattern select keeps its current value
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      ptr_d   = ptr_q;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode (from next state, registered below)
  // -------------------------------------------------------------------------
  always_comb begin
    gen_rstb_d = (state_d == S_PRE) || (state_d == S_RUN);
    prbs_en_d  = (state_d == S_RUN);
    vld_d      = (state_d == S_RUN);
    busy_d     = (state_d == S_RST) || (state_d == S_PRE) || (state_d == S_RUN);
    gen_inv_d  = busy_d && inv_d;
    done_d     = (state_d == S_DONE) || empty_start;
  end

  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) begin
      gen_rstb_q <= 1'b0;
      prbs_en_q  <= 1'b0;
      gen_inv_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      gen_rstb_q <= gen_rstb_d;
      prbs_en_q  <= prbs_en_d;
      gen_inv_q  <= gen_inv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      vld_q      <= vld_d;
    end
  end

  assign bus.gen_rstb     = gen_rstb_q;
  assign bus.gen_prbs_en  = prbs_en_q;
  assign bus.gen_inv      = gen_inv_q;
  assign bus.gen_ptrn_sel = ptr_q;   // ptr_q only changes on RST entry
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.data_vld     = vld_q;

  // -------------------------------------------------------------------------
  // Segment statistics
  // -------------------------------------------------------------------------
`ifdef PRBS_SEQ_STAT_EN
  logic [7:0] seg_q, seg_d;
  logic       seg_clr, seg_inc;

  assign seg_clr = (state_q == S_IDLE) && (state_d == S_RST);
  // last RUN cycle completes a segment unless abort cuts it off
  assign seg_inc = (state_q == S_RUN) && (cnt_q == CW'(1)) && !bus.abort;

  always_comb begin
    seg_d = seg_q;
    if (seg_clr)      seg_d = 8'd0;
    else if (seg_inc) seg_d = seg_q + 8'd1;
  end

  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) seg_q <= 8'd0;
    else        seg_q <= seg_d;
  end

  assign bus.seg_cnt = seg_q;
`else
  assign bus.seg_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_prbs_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_prbs_seq_ctrl
//   Bench for prbs_seq_ctrl. A reference model expands each requested
//   sequence into its expected per-cycle output trace (one packed word per
//   cycle) and the DUT outputs are compared against it every cycle.
//   A small CNT_W keeps the burst_len=0 (2^CNT_W) case short.
// ---------------------------------------------------------------------------
module tb_prbs_seq_ctrl;
  localparam int CNT_W = 6;
  localparam int PRE_W = 4;

  logic clk   = 1'b0;
  logic arstb = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] last_sel;
  int         cur_seg;

  prbs_seq_ctrl_if #(.CNT_W(CNT_W), .PRE_W(PRE_W)) bus ();

  prbs_seq_ctrl #(.CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk   (clk),
    .arstb (arstb),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // packed word: rstb prbs_en inv sel[1:0] busy done vld seg[7:0]
  function automatic logic [15:0] mk(input logic rstb, input logic en, input logic inv,
                                     input logic [1:0] sel, input logic busy, input logic dn,
                                     input logic vld, input int seg);
    logic [7:0] s;
`ifdef PRBS_SEQ_STAT_EN
    s = 8'(seg);
`else
    s = 8'h00;
`endif
    return {rstb, en, inv, sel, busy, dn, vld, s};
  endfunction

  function automatic logic [15:0] obs();
    return {bus.gen_rstb, bus.gen_prbs_en, bus.gen_inv, bus.gen_ptrn_sel,
            bus.busy, bus.done, bus.data_vld, bus.seg_cnt};
  endfunction

  // Issue one start with the given config and check every following cycle.
  // abort_at>0 raises abort during that cycle (1 = first cycle after start).
  // jitter scrambles config inputs and pulses start while the sequence runs.
  task automatic run_seq(input string name, input logic [3:0] mask, input int pre,
                         input int burst, input bit inv, input bit lp,
                         input int abort_at, input bit jitter);
    logic [15:0] q[$];
    logic [15:0] fin;
    logic [1:0]  last;
    int          seg, blen, ncyc;
    blen = (burst == 0) ? (1 << CNT_W) : burst;
    seg  = cur_seg;
    last = last_sel;
    if (mask == 4'h0) begin
      q.push_back(mk(0, 0, 0, last, 0, 1, 0, seg));
    end else begin
      seg = 0;
      do begin
        for (int p = 0; p < 4; p++) begin
          if (mask[p]) begin
            q.push_back(mk(0, 0, inv, 2'(p), 1, 0, 0, seg));
            repeat (pre)  q.push_back(mk(1, 0, inv, 2'(p), 1, 0, 0, seg));
            repeat (blen) q.push_back(mk(1, 1, inv, 2'(p), 1, 0, 1, seg));
            seg  = (seg + 1) % 256;
            last = 2'(p);
          end
        end
      end while (lp && (q.size() < abort_at));
      if (!lp) q.push_back(mk(0, 0, 0, last, 0, 1, 0, seg));
    end
    ncyc = (abort_at > 0 && abort_at <= q.size()) ? abort_at : q.size();

    @(negedge clk);
    bus.ptrn_mask = mask;
    bus.burst_len = CNT_W'(burst);
    bus.pre_len   = PRE_W'(pre);
    bus.inv_cfg   = inv;
    bus.loop      = lp;
    bus.abort     = 1'b0;
    bus.start     = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk($sformatf("%s c%0d", name, k), 32'(obs()), 32'(q[k-1]));
      if (k == abort_at) begin
        bus.abort = 1'b1;
      end else if (jitter && mask != 4'h0) begin
        bus.ptrn_mask = 4'($urandom);
        bus.burst_len = CNT_W'($urandom);
        bus.pre_len   = PRE_W'($urandom);
        bus.inv_cfg   = 1'($urandom);
        bus.loop      = 1'($urandom);
        bus.start     = ($urandom_range(0, 3) == 0);
      end
    end
    fin  = q[ncyc-1];
    last = fin[12:11];
    seg  = int'(fin[7:0]);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk($sformatf("%s idle%0d", name, k), 32'(obs()), 32'(mk(0, 0, 0, last, 0, 0, 0, seg)));
    end
    last_sel = last;
    cur_seg  = seg;
  endtask

  initial begin
    logic [3:0] m;
    int         pr, bl, ab;
    bit         iv, lp, jt;

    bus.start = 1'b0; bus.abort = 1'b0; bus.ptrn_mask = 4'h0;
    bus.burst_len = '0; bus.pre_len = '0; bus.inv_cfg = 1'b0; bus.loop = 1'b0;
    last_sel = 2'd0;
    cur_seg  = 0;

    #12;
    chk("reset", 32'(obs()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    arstb = 1'b1;

    run_seq("single",     4'b0001, 4, 10, 0, 0, 0,  0);
    run_seq("two_pat",    4'b1010, 0, 3,  1, 0, 0,  0);
    run_seq("loop_abort", 4'b0101, 2, 3,  0, 1, 19, 0);
`ifdef PRBS_SEQ_STAT_EN
    chk("seg_after_abort", 32'(bus.seg_cnt), 32'd3);
`else
    chk("seg_after_abort", 32'(bus.seg_cnt), 32'd0);
`endif
    run_seq("empty_mask", 4'b0000, 1, 1,  0, 0, 0,  0);

    // abort together with start in IDLE: nothing happens
    @(negedge clk);
    bus.ptrn_mask = 4'b0001; bus.start = 1'b1; bus.abort = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      chk($sformatf("start_abort c%0d", k), 32'(obs()),
          32'(mk(0, 0, 0, last_sel, 0, 0, 0, cur_seg)));
    end

    run_seq("burst_max", 4'b0100, 1, 0, 1, 0, 0, 0);
    run_seq("jitter",    4'b1011, 2, 4, 1, 0, 0, 1);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    bus.ptrn_mask = 4'b0100; bus.pre_len = PRE_W'(1); bus.burst_len = CNT_W'(20);
    bus.inv_cfg = 1'b1; bus.loop = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_arst_run", 32'(obs()), 32'(mk(1, 1, 1, 2, 1, 0, 1, 0)));
    #2 arstb = 1'b0;
    #1 chk("arst_async", 32'(obs()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    arstb    = 1'b1;
    last_sel = 2'd0;
    cur_seg  = 0;
    run_seq("after_arst", 4'b1000, 3, 5, 0, 0, 0, 0);

    for (int t = 0; t < 25; t++) begin
      m  = 4'($urandom_range(0, 15));
      pr = $urandom_range(0, 5);
      bl = $urandom_range(0, 9);
      iv = 1'($urandom_range(0, 1));
      lp = 1'($urandom_range(0, 1));
      if (m == 4'h0)  ab = 0;
      else if (lp)    ab = $urandom_range(1, 60);
      else            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
      jt = 1'($urandom_range(0, 1));
      run_seq($sformatf("rnd%0d", t), m, pr, bl, iv, lp, ab, jt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
